// File: rtl/lt24_bus_writer.sv
// lt24_bus_writer: LT24 8080-style write-bus engine with panel power-up reset sequencing.
// Define LT24_HW_RESET_EN to run the timed RST_LOW/RST_WAIT sequence; otherwise LT24Reset_n follows globalReset.
module lt24_bus_writer #(
    parameter int RESET_LOW_CYCLES  = 500000,
    parameter int RESET_WAIT_CYCLES = 6000000,
    parameter int WR_LOW_CYCLES     = 2,
    parameter int WR_HIGH_CYCLES    = 1
) (
    input  logic        clock,
    input  logic        globalReset,
    input  logic [15:0] cmdData,
    input  logic        cmdIsData,
    input  logic        cmdValid,
    output logic        cmdReady,
    output logic        initDone,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Reset_n,
    output logic [15:0] LT24Data,
    output logic        LT24LCDOn
);
    localparam int MAXP = RESET_WAIT_CYCLES > RESET_LOW_CYCLES ?
                          (RESET_WAIT_CYCLES > WR_LOW_CYCLES + WR_HIGH_CYCLES ? RESET_WAIT_CYCLES : WR_LOW_CYCLES + WR_HIGH_CYCLES) :
                          (RESET_LOW_CYCLES > WR_LOW_CYCLES + WR_HIGH_CYCLES ? RESET_LOW_CYCLES : WR_LOW_CYCLES + WR_HIGH_CYCLES);
    localparam int CW = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, WR_LOW, WR_HIGH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, lim;
    logic [15:0]   data_q;
    logic          rs_q, done, accept;

    always_comb begin
        lim = state == WR_LOW   ? CW'(WR_LOW_CYCLES - 1) :
              state == WR_HIGH  ? CW'(WR_HIGH_CYCLES - 1) :
              state == RST_WAIT ? CW'(RESET_WAIT_CYCLES - 1) : CW'(RESET_LOW_CYCLES - 1);
        done = cnt == lim;
        cmdReady = state == IDLE || (state == WR_HIGH && done);
        accept = cmdValid && cmdReady;
        state_n = state;
        case (state)
`ifdef LT24_HW_RESET_EN
            RST_LOW:  state_n = done ? RST_WAIT : RST_LOW;
            RST_WAIT: state_n = done ? IDLE : RST_WAIT;
`else
            RST_LOW, RST_WAIT: state_n = IDLE;
`endif
            IDLE:     state_n = accept ? WR_LOW : IDLE;
            WR_LOW:   state_n = done ? WR_HIGH : WR_LOW;
            WR_HIGH:  state_n = done ? (accept ? WR_LOW : IDLE) : WR_HIGH;
            default:  state_n = RST_LOW;
        endcase
    end

    // Counter restarts on every state entry and idles at zero, so it never wraps.
    always_ff @(posedge clock) begin
        if (!globalReset) begin
            state  <= RST_LOW;
            cnt    <= '0;
            data_q <= '0;
            rs_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
            if (accept) begin
                data_q <= cmdData;
                rs_q   <= cmdIsData;
            end
        end
    end

    assign initDone  = state == IDLE || state == WR_LOW || state == WR_HIGH;
    assign LT24LCDOn = initDone;
    assign LT24CS_n  = !(state == WR_LOW || state == WR_HIGH);
    assign LT24Wr_n  = state != WR_LOW;
    assign LT24Rd_n  = 1'b1;
    assign LT24RS    = rs_q;
    assign LT24Data  = data_q;

`ifdef LT24_HW_RESET_EN
    assign LT24Reset_n = state != RST_LOW;
`else
    logic rst_q;
    always_ff @(posedge clock) rst_q <= globalReset;
    assign LT24Reset_n = rst_q;
`endif
endmodule

// File: tb/tb_lt24_bus_writer.sv
// tb_lt24_bus_writer: randomized bench for lt24_bus_writer against a cycle-count reference model.
module tb_lt24_bus_writer;
    localparam int RL = 4, RW = 6, WL = 2, WH = 1;

    logic        clock = 1'b0;
    logic        globalReset = 1'b0;
    logic [15:0] cmdData = '0;
    logic        cmdIsData = 1'b0, cmdValid = 1'b0;
    logic        cmdReady, initDone, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
    logic [15:0] LT24Data;

    always #5 clock = ~clock;

    lt24_bus_writer #(
        .RESET_LOW_CYCLES(RL), .RESET_WAIT_CYCLES(RW), .WR_LOW_CYCLES(WL), .WR_HIGH_CYCLES(WH)
    ) dut (
        .clock(clock), .globalReset(globalReset), .cmdData(cmdData), .cmdIsData(cmdIsData),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .initDone(initDone), .LT24Wr_n(LT24Wr_n),
        .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n),
        .LT24Data(LT24Data), .LT24LCDOn(LT24LCDOn)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: cyc = edges since reset release, pos = cycle index within the current write (-1 = no write).
    int          cyc = 0, pos = -1;
    logic [15:0] m_data = '0;
    logic        m_rs = 1'b0;
    bit          armed = 0;

    function automatic bit m_init();
`ifdef LT24_HW_RESET_EN
        return cyc >= RL + RW;
`else
        return cyc >= 1;
`endif
    endfunction

    function automatic bit m_resetn();
`ifdef LT24_HW_RESET_EN
        return cyc >= RL;
`else
        return cyc >= 1;
`endif
    endfunction

    function automatic bit m_ready();
        return m_init() && (pos < 0 || pos == WL + WH - 1);
    endfunction

    initial begin
        bit acc;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (armed) begin
                check("bus {cs,wr,rd,rs,rstn,lcd,rdy,init}",
                      {24'd0, LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24Reset_n, LT24LCDOn, cmdReady, initDone},
                      {24'd0, pos < 0, !(pos >= 0 && pos < WL), 1'b1, m_rs, m_resetn(), m_init(), m_ready(), m_init()});
                check("data", {16'd0, LT24Data}, {16'd0, m_data});
            end
            globalReset = i < 3 ? 1'b0 : (i < 100 ? 1'b1 : ($urandom_range(0, 99) != 0));
            cmdValid = i < 100 ? 1'b1 :
                       ((i / 300) % 3 == 0) ? 1'b1 :
                       ((i / 300) % 3 == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) == 0);
            cmdData = 16'($urandom);
            cmdIsData = 1'($urandom);
            @(posedge clock);
            if (!globalReset) begin
                cyc = 0;
                pos = -1;
                m_data = '0;
                m_rs = 1'b0;
                armed = 1;
            end else begin
                acc = cmdValid && m_ready();
                if (acc) begin
                    pos = 0;
                    m_data = cmdData;
                    m_rs = cmdIsData;
                end else if (pos >= 0) begin
                    pos = (pos == WL + WH - 1) ? -1 : pos + 1;
                end
                if (cyc < 1000000) cyc++;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
